mem_fetch_stage: RTL

Memory-side stage of the multi-cycle RISC-V core, directly downstream of the control unit. It owns the PC, OldPC, instruction and data registers and the address multiplexer. It converts the control unit's IRWrite/MemWrite/AdrSrc/PCWrite strobes into request/ready transactions on a variable-latency memory bus. It drives Stall back to the control unit so that the control FSM holds its state while an access is outstanding.

---
 rtl/mem_fetch_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_fetch_stage.sv
// rtl/mem_fetch_stage.sv - memory-side stage: PC/OldPC/Instr/Data registers and request/ready bus access
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   PCWrite                  commit Result into PC when not stalled
//   AdrSrc                   address select (0 = PC, 1 = Result)
//   IRWrite, MemWrite        fetch / store strobes (AdrSrc alone with no MemWrite = load)
//   Result, WriteData        next-PC/data address and store data from the datapath
//   mem_req/we/addr/wdata    bus request side
//   mem_rdata, mem_ready     bus response side
//   PC, OldPC, Instr, Data   architectural registers
//   Stall                    holds the control FSM while an access is outstanding
//   bus_err                  sticky access-timeout flag
module mem_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        AdrSrc,
    input  logic        IRWrite,
    input  logic        MemWrite,
    input  logic [31:0] Result,
    input  logic [31:0] WriteData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic [31:0] OldPC,
    output logic [31:0] Instr,
    output logic [31:0] Data,
    output logic        Stall,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {KIND_FETCH, KIND_LOAD, KIND_STORE} kind_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [7:0]  wcnt;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_we;
    kind_t       lat_kind;

    logic        acc;
    kind_t       issue_kind;
    kind_t       commit_kind;
    logic        commit, abort, launch;

    always_comb begin
        acc = IRWrite | MemWrite | (AdrSrc & ~MemWrite);
        // MemWrite wins over IRWrite so the illegal double strobe behaves as a store
        issue_kind = MemWrite ? KIND_STORE : (IRWrite ? KIND_FETCH : KIND_LOAD);

        state_nxt   = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = lat_addr;
        mem_wdata   = lat_wdata;
        Stall       = 1'b0;
        commit      = 1'b0;
        abort       = 1'b0;
        launch      = 1'b0;
        commit_kind = issue_kind;

        case (state)
            IDLE: begin
                mem_req   = acc;
                mem_we    = MemWrite;
                mem_addr  = AdrSrc ? Result : PC;
                mem_wdata = WriteData;
                if (acc) begin
                    if (mem_ready) begin
                        commit = 1'b1;
                    end else begin
                        launch    = 1'b1;
                        Stall     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // Live strobes may already belong to the next control state;
                // the bus sees only the copies captured at issue.
                mem_req     = 1'b1;
                mem_we      = lat_we;
                commit_kind = lat_kind;
                if (mem_ready) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end else if (wcnt == TMAX) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= 8'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_we    <= 1'b0;
            lat_kind  <= KIND_FETCH;
            PC        <= RESET_PC;
            OldPC     <= 32'd0;
            Instr     <= 32'd0;
            Data      <= 32'd0;
            bus_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (launch) begin
                lat_addr  <= AdrSrc ? Result : PC;
                lat_we    <= MemWrite;
                lat_wdata <= WriteData;
                lat_kind  <= issue_kind;
                wcnt      <= 8'd1;
            end else if (state == BUSY && Stall) begin
                wcnt <= wcnt + 8'd1;
            end

            if (commit) begin
                case (commit_kind)
                    KIND_FETCH: begin
                        Instr <= mem_rdata;
                        OldPC <= PC;
                    end
                    KIND_LOAD: Data <= mem_rdata;
                    default: ;
                endcase
            end

            if (abort) begin
                bus_err <= 1'b1;
            end

            // An aborted access leaves every register untouched, PC included
            if (PCWrite && !Stall && !abort) begin
                PC <= Result;
            end
        end
    end

endmodule
